// File: rtl/aq_f_spsram_64x58_ctrl.sv
// aq_f_spsram_64x58_ctrl: clear sequencer and write/read arbiter in front of a single-port SRAM.
// Reads are granted over writes once starved for STARVE_LIMIT cycles; Q is passed straight back.
module aq_f_spsram_64x58_ctrl #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 58,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  inv_req,
    output logic                  init_busy,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_bmask,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_rvalid,
    output logic [DATA_WIDTH-1:0] rd_rdata,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic [DATA_WIDTH-1:0] sram_d,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    input  logic [DATA_WIDTH-1:0] sram_q
);
    typedef enum logic {INIT, IDLE} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]            starve_q, starve_d;
    logic                  rvalid_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_gnt    = 1'b0;
        rd_gnt    = 1'b0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b0;
        sram_a    = '0;
        sram_d    = '0;
        sram_wen  = '0;
        init_busy = (state_q == INIT);
        if (!RST) begin
            if (state_q == INIT) begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b1;
                sram_wen  = '1;
                sram_a    = cnt_q;
                cnt_d     = cnt_q + 1'b1;
                state_d   = (cnt_q == '1) ? IDLE : INIT;
            end else if (inv_req) begin
                state_d = INIT;
                cnt_d   = '0;
            end else begin
                wr_gnt = wr_req && !(rd_req && starve_q == 4'(STARVE_LIMIT));
                rd_gnt = rd_req && !wr_gnt;
                if (wr_gnt) begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b1;
                    sram_a    = wr_addr;
                    sram_d    = wr_data;
                    sram_wen  = wr_bmask;
                end else if (rd_gnt) begin
                    sram_cen = 1'b0;
                    sram_a   = rd_addr;
                end
            end
        end
        // Denied reads count only while arbitrating; the count survives a clear if the read stays pending.
        starve_d = (!rd_req || rd_gnt) ? 4'd0 :
                   (state_q == IDLE && starve_q != 4'(STARVE_LIMIT)) ? starve_q + 4'd1 : starve_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= INIT;
            cnt_q    <= '0;
            starve_q <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            rvalid_q <= rd_gnt;
        end
    end

    assign rd_rvalid = rvalid_q;
    assign rd_rdata  = sram_q;
endmodule

// File: tb/tb_aq_f_spsram_64x58_ctrl.sv
// tb_aq_f_spsram_64x58_ctrl: directed bench with an SRAM behavioural model and a per-cycle reference model.
module tb_aq_f_spsram_64x58_ctrl;
    localparam int AW = 6;
    localparam int DW = 58;
    localparam int LIM = 4;
    localparam logic [DW-1:0] ONES = '1;

    logic          CLK = 1'b0, RST = 1'b1, inv_req = 1'b0;
    logic          wr_req = 1'b0, rd_req = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0, wr_bmask = '0;
    logic          init_busy, wr_gnt, rd_gnt, rd_rvalid, sram_cen, sram_gwen;
    logic [DW-1:0] rd_rdata, sram_d, sram_wen, sram_q;
    logic [AW-1:0] sram_a;

    int n_chk = 0, n_err = 0;

    aq_f_spsram_64x58_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
        .CLK(CLK), .RST(RST), .inv_req(inv_req), .init_busy(init_busy),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bmask(wr_bmask), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_d(sram_d), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_q(sram_q)
    );

    always #5 CLK = ~CLK;

    // SRAM macro: registered Q, bit-masked writes; starts with garbage so the clear is observable.
    logic [DW-1:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] = DW'({$urandom(), $urandom()});
    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (sram_gwen) mem[sram_a] <= (mem[sram_a] & ~sram_wen) | (sram_d & sram_wen);
            else sram_q <= mem[sram_a];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: array contents, clear progress and read-wait count.
    logic [DW-1:0] ref_mem [64];
    int            clr_left = 64, clr_addr = 0, waitc = 0;
    logic          exp_rv = 1'b0;
    logic [DW-1:0] exp_rd = '0;

    always @(negedge CLK) begin
        logic ew, er, busy;
        logic [DW-1:0] nd;
        ew = 1'b0; er = 1'b0; nd = '0;
        busy = clr_left > 0;
        if (RST) begin
            chk("rst_cen", sram_cen, 1);
            chk("rst_gwen", sram_gwen, 0);
            clr_left = 64; clr_addr = 0; waitc = 0;
        end else begin
            chk("init_busy", init_busy, busy);
            if (busy) begin
                chk("clr_a", sram_a, clr_addr);
                chk("clr_cen", sram_cen, 0);
                chk("clr_gwen", sram_gwen, 1);
                chk("clr_d", sram_d, 0);
                chk("clr_wen", sram_wen, ONES);
                ref_mem[clr_addr] = '0;
                clr_addr = (clr_addr + 1) % 64;
                clr_left--;
            end else if (inv_req) begin
                chk("inv_cen", sram_cen, 1);
                clr_left = 64; clr_addr = 0;
            end else begin
                ew = wr_req && !(rd_req && waitc >= LIM);
                er = rd_req && !ew;
                if (ew) begin
                    chk("w_cen", sram_cen, 0);
                    chk("w_gwen", sram_gwen, 1);
                    chk("w_a", sram_a, wr_addr);
                    chk("w_d", sram_d, wr_data);
                    chk("w_wen", sram_wen, wr_bmask);
                    ref_mem[wr_addr] = (ref_mem[wr_addr] & ~wr_bmask) | (wr_data & wr_bmask);
                end else if (er) begin
                    chk("r_cen", sram_cen, 0);
                    chk("r_gwen", sram_gwen, 0);
                    chk("r_a", sram_a, rd_addr);
                    chk("r_wen", sram_wen, 0);
                    nd = ref_mem[rd_addr];
                end else begin
                    chk("n_cen", sram_cen, 1);
                    chk("n_gwen", sram_gwen, 0);
                    chk("n_a", sram_a, 0);
                    chk("n_d", sram_d, 0);
                    chk("n_wen", sram_wen, 0);
                end
            end
            waitc = (!rd_req || er) ? 0 : (!busy && waitc < LIM) ? waitc + 1 : waitc;
        end
        chk("wr_gnt", wr_gnt, ew);
        chk("rd_gnt", rd_gnt, er);
        chk("rd_rvalid", rd_rvalid, exp_rv);
        if (exp_rv) chk("rd_rdata", rd_rdata, exp_rd);
        exp_rv = er;
        exp_rd = nd;
    end

    task automatic sync;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        int n;
        wr_req = 1'b1; wr_addr = a; wr_data = d; wr_bmask = m;
        n = 0;
        @(negedge CLK);
        while (!wr_gnt && n < 100) begin n++; @(negedge CLK); end
        chk("wr_gnt_seen", wr_gnt, 1);
        sync;
        wr_req = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int waited);
        int n;
        rd_req = 1'b1; rd_addr = a;
        n = 0;
        @(negedge CLK);
        while (!rd_gnt && n < 100) begin n++; @(negedge CLK); end
        chk("rd_gnt_seen", rd_gnt, 1);
        sync;
        rd_req = 1'b0;
        @(negedge CLK);
        d = rd_rdata;
        waited = n;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        int n;
        string s;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        n = 0;
        @(negedge CLK);
        while (init_busy && n < 200) begin n++; @(negedge CLK); end
        chk("init_len", n, 64);
        sync;
        do_read(6'd17, d, n);
        chk("clr_rd17", d, 0);
        sync;
        do_read(6'd63, d, n);
        chk("clr_rd63", d, 0);

        sync;
        do_write(6'd5, 58'h2AB_CDEF_0123_4567, ONES);
        do_read(6'd5, d, n);
        chk("raw_wait", n, 0);
        chk("raw_data", d, 58'h2AB_CDEF_0123_4567);

        sync;
        do_write(6'd9, ONES, ONES);
        do_write(6'd9, '0, 58'hFF);
        do_read(6'd9, d, n);
        chk("mask_data", d, 58'h3FF_FFFF_FFFF_FF00);

        sync;
        wr_req = 1'b1; wr_addr = 6'd20; wr_data = 58'h123; wr_bmask = ONES;
        rd_req = 1'b1; rd_addr = 6'd5;
        s = "";
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            s = {s, wr_gnt ? "W" : rd_gnt ? "R" : "-"};
        end
        n_chk++;
        if (s != "WWWWRWWWWRWWWWR") begin
            n_err++;
            $display("FAIL starve_pattern: got %s expected WWWWRWWWWRWWWWR", s);
        end
        sync;
        wr_req = 1'b0; rd_req = 1'b0;

        sync;
        inv_req = 1'b1;
        wr_req = 1'b1; wr_addr = 6'd30; wr_data = 58'h3A5; wr_bmask = ONES;
        rd_req = 1'b1; rd_addr = 6'd5;
        @(negedge CLK);
        chk("inv_wr_gnt", wr_gnt, 0);
        chk("inv_rd_gnt", rd_gnt, 0);
        sync;
        inv_req = 1'b0;
        n = 0;
        @(negedge CLK);
        while (!(wr_gnt || rd_gnt) && n < 200) begin n++; @(negedge CLK); end
        chk("inv_wait", n, 64);
        chk("inv_first_wr", wr_gnt, 1);
        sync;
        wr_req = 1'b0;
        @(negedge CLK);
        chk("inv_then_rd", rd_gnt, 1);
        sync;
        rd_req = 1'b0;
        @(negedge CLK);
        chk("inv_rd5", rd_rdata, 0);

        sync;
        RST = 1'b1; rd_req = 1'b1; rd_addr = 6'd3;
        @(negedge CLK);
        chk("rst_rd_gnt", rd_gnt, 0);
        sync;
        rd_req = 1'b0;
        @(negedge CLK);
        chk("rst_rvalid", rd_rvalid, 0);
        chk("rst_busy", init_busy, 1);
        sync;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_restart_a", sram_a, 0);
        n = 0;
        while (init_busy && n < 200) begin n++; @(negedge CLK); end
        chk("reinit_len", n, 64);
        sync;
        do_read(6'd20, d, n);
        chk("reinit_rd20", d, 0);

        sync;
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/aq_f_spsram_64x58_ctrl.md
Name: aq_f_spsram_64x58_ctrl

Overview:
- Sequencer and arbiter in front of one 64x58 single-port SRAM wrapper (ports A, CEN, CLK, D, GWEN, WEN, Q).
- Shares the array between a write requester (fill/update) and a read requester (lookup).
- Zero-clears every entry after reset and on an explicit invalidate.
- Sits between the cache-tag/BHT-style control logic and the SRAM macro wrapper; one instance per array.

Parameters:
- ADDR_WIDTH, 6, SRAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 58, SRAM data width.
- STARVE_LIMIT, 4, consecutive read-denied cycles before the read requester wins over the write requester; legal 1..15.

Ports:
- CLK  in  1  clock; also drives the SRAM wrapper CLK.
- RST  in  1  synchronous reset, active-high.
- inv_req  in  1  start a full-array clear.
- init_busy  out  1  clear sequence in progress.
- wr_req  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_bmask  in  DATA_WIDTH  per-bit write enable, 1 = write the bit.
- wr_gnt  out  1  write accepted this cycle.
- rd_req  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_gnt  out  1  read accepted this cycle.
- rd_rvalid  out  1  rd_rdata is valid; asserted one cycle after rd_gnt.
- rd_rdata  out  DATA_WIDTH  read data.
- sram_a  out  ADDR_WIDTH  to SRAM A.
- sram_cen  out  1  to SRAM CEN, active-low chip enable.
- sram_d  out  DATA_WIDTH  to SRAM D.
- sram_gwen  out  1  to SRAM GWEN, 1 = write (the wrapper inverts it).
- sram_wen  out  DATA_WIDTH  to SRAM WEN, 1 = bit written (the wrapper inverts it).
- sram_q  in  DATA_WIDTH  from SRAM Q.

Behaviour:
- Clock and reset: one clock CLK. Reset RST is synchronous and active-high.
- FSM states: INIT, IDLE.
  - RST drives the FSM to INIT and the clear counter to 0.
  - Also reset: rd_rvalid=0, starve counter=0.
- INIT:
  - init_busy=1; wr_gnt=0; rd_gnt=0.
  - Each cycle: sram_cen=0, sram_gwen=1, sram_wen=all-ones, sram_d=0, sram_a=counter; counter increments.
  - After writing address 2**ADDR_WIDTH-1 (64 cycles for the default depth), the FSM goes to IDLE. The counter wraps to 0.
  - inv_req during INIT is ignored; the sequence does not restart.
- IDLE:
  - inv_req=1 wins over all requests. No grant that cycle; next state INIT, counter=0.
  - Otherwise, arbitration is combinational within the cycle.
    - Read priority holds when starve counter == STARVE_LIMIT; otherwise write has priority.
    - A sole requester is always granted.
  - Write grant: sram_cen=0, sram_gwen=1, sram_a=wr_addr, sram_d=wr_data, sram_wen=wr_bmask.
  - Read grant: sram_cen=0, sram_gwen=0, sram_a=rd_addr, sram_wen=0.
  - No grant: sram_cen=1, sram_gwen=0, sram_wen=0, sram_a=0, sram_d=0.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when rd_req=1 and rd_gnt=0 in IDLE.
  - Clears to 0 on rd_gnt or when rd_req=0.
- Requester handshake:
  - A requester holds req and its payload until it sees gnt in the same cycle.
  - gnt depends only on the current req/state; there is no stall once granted.
- Read return:
  - rd_rvalid is a register: rd_rvalid <= rd_gnt.
  - rd_rdata = sram_q, passed straight through. It is valid only while rd_rvalid=1.
  - Back-to-back reads give one result per cycle.
- Read/write ordering:
  - A read granted the cycle after a write to the same address returns the new data.
  - Same-cycle read and write are never both granted.
- Reset mid-operation:
  - A read granted in the cycle RST rises yields rd_rvalid=0 next cycle.
  - Clearing restarts from address 0.
- Reset value of outputs while RST=1: wr_gnt=0, rd_gnt=0, sram_cen=1, sram_gwen=0, init_busy=1 from the following cycle.

Test Plan:
- Release RST -> init_busy=1 for exactly 64 cycles; sram_a steps 0..63 with sram_gwen=1, sram_d=0, sram_wen=all-ones; then init_busy=0. A read of any address returns 0.
- After init: write addr 5, data 58'h2AB_CDEF_0123_4567, full mask; next cycle read addr 5 -> rd_gnt same cycle, rd_rvalid=1 one cycle later with that data.
- Partial mask: write 0 to addr 9 with mask 58'hFF, after a full write of all-ones -> readback 58'h3FF_FFFF_FFFF_FF00.
- Hold wr_req and rd_req continuously (STARVE_LIMIT=4) -> grant pattern W,W,W,W,R repeating; the read is never starved longer than 4 cycles.
- inv_req pulse with wr_req and rd_req pending -> no grant that cycle; 64 clear cycles follow; requests granted only after init_busy=0; all prior data reads back as 0.
- Assert RST in the cycle a read is granted -> rd_rvalid=0 next cycle; the clear restarts at address 0.
